// File: rtl/vote_pkg.sv
// Shared definitions for the ballot front-end.
// Holds the candidate count, the candidate index width, the controller
// state type and the selection helpers. Ports: none (package).
package vote_pkg;

    // Candidate buttons are one-hot. This revision of the machine has four.
    localparam int N_CAND = 4;
    localparam int CAND_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_REL,
        WAIT_REL_RETRY
    } vote_state_t;

    // True when exactly one candidate button is pressed.
    function automatic logic is_onehot(input logic [N_CAND-1:0] sel);
        return $onehot(sel);
    endfunction

    // Binary index of a one-hot selection: bit0->0 ... bit3->3.
    function automatic logic [CAND_W-1:0] onehot_to_idx(input logic [N_CAND-1:0] sel);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (sel[i]) idx = CAND_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// Input conditioning for the ballot controller.
// Two-flop synchronizers for the raw ballot key and candidate buttons, a
// rising-edge detector on the ballot key and a stability counter on the
// synchronized buttons.
// Ports:
//   clk, rst     clock and async active-high reset
//   clr          synchronous clear (machine power low)
//   ballot       raw ballot key (asynchronous level)
//   btn_in       raw candidate buttons (asynchronous)
//   btn_sync     synchronized buttons
//   btn_stable   btn_sync has held for DEBOUNCE_CYC identical samples
//   ballot_rise  one-cycle 0->1 edge of the synchronized ballot key
module vote_debounce
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ballot,
    input  logic [N_CAND-1:0] btn_in,
    output logic [N_CAND-1:0] btn_sync,
    output logic              btn_stable,
    output logic              ballot_rise
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic [N_CAND-1:0] btn_meta;
    logic [2:0]        ballot_sh;   // [0] first flop, [1] synchronized, [2] previous synchronized
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  stable_cnt_next;

    // btn_meta is the value btn_sync takes at the next edge, so comparing the
    // two tells whether the synchronized value is about to change.
    always_comb begin
        if (btn_meta != btn_sync) begin
            stable_cnt_next = '0;
        end else if (stable_cnt == CNT_MAX) begin
            stable_cnt_next = CNT_MAX;
        end else begin
            stable_cnt_next = stable_cnt + CNT_W'(1);
        end
    end

    // Stability is judged on the count this edge is about to store, so the
    // controller acts on the same edge the last required sample lands.
    assign btn_stable  = (stable_cnt_next == CNT_MAX);
    assign ballot_rise = ballot_sh[1] & ~ballot_sh[2];

    // NOTE: every register here is updated with <= so all flops sample the
    // pre-edge values; blocking assignments would collapse the synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            ballot_sh  <= '0;
            stable_cnt <= '0;
        end else if (clr) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            ballot_sh  <= '0;
            stable_cnt <= '0;
        end else begin
            btn_meta   <= btn_in;
            btn_sync   <= btn_meta;
            ballot_sh  <= {ballot_sh[1:0], ballot};
            stable_cnt <= stable_cnt_next;
        end
    end

endmodule

// File: rtl/vote_ballot_ctrl.sv
// Ballot front-end feeding the vote counter.
// Arms one ballot per presiding-officer key press, accepts a single debounced
// one-hot candidate selection, flags multi-hot selections and expires idle
// ballots. All outputs are registered; at most one pulse is high per cycle.
// Ports:
//   clk, rst      clock and async active-high reset
//   power         machine power; low holds the block in a synchronous clear
//   closed        poll closed; blocks new ballot authorizations
//   ballot        raw ballot key
//   btn_in        raw candidate buttons (width vote_pkg::N_CAND)
//   armed         a ballot is issued and a vote is pending
//   vote_valid    one-cycle pulse for an accepted vote
//   vote_cand     candidate index, meaningful only with vote_valid
//   vote_invalid  one-cycle pulse for a stable multi-hot selection
//   vote_timeout  one-cycle pulse when an armed ballot expires
module vote_ballot_ctrl
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              closed,
    input  logic              ballot,
    input  logic [N_CAND-1:0] btn_in,
    output logic              armed,
    output logic              vote_valid,
    output logic [CAND_W-1:0] vote_cand,
    output logic              vote_invalid,
    output logic              vote_timeout
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [N_CAND-1:0] btn_sync;
    logic              btn_stable;
    logic              ballot_rise;

    vote_state_t       state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_cnt_inc;
    logic              expired, sel_ready;
    logic              armed_d, valid_d, invalid_d, timeout_d;
    logic [CAND_W-1:0] cand_d;

    vote_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .clr        (!power),
        .ballot     (ballot),
        .btn_in     (btn_in),
        .btn_sync   (btn_sync),
        .btn_stable (btn_stable),
        .ballot_rise(ballot_rise)
    );

    // NOTE: every signal written below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        valid_d    = 1'b0;
        cand_d     = '0;
        invalid_d  = 1'b0;
        timeout_d  = 1'b0;
        expired    = (to_cnt_q == TO_LAST);
        to_cnt_inc = expired ? to_cnt_q : to_cnt_q + TO_W'(1);
        sel_ready  = btn_stable && (btn_sync != '0);

        case (state_q)
            IDLE: begin
                // closed outranks a simultaneous key press
                if (ballot_rise && !closed) begin
                    state_d  = ARMED;
                    to_cnt_d = '0;
                end
            end
            ARMED: begin
                // A decided selection outranks expiry on the same cycle.
                if (sel_ready && is_onehot(btn_sync)) begin
                    valid_d = 1'b1;
                    cand_d  = onehot_to_idx(btn_sync);
                    state_d = WAIT_REL;
                end else if (sel_ready) begin
                    invalid_d = 1'b1;
                    to_cnt_d  = to_cnt_inc;
                    state_d   = WAIT_REL_RETRY;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            WAIT_REL_RETRY: begin
                // Ballot is still live: the timeout keeps running, no reload.
                if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (btn_stable && (btn_sync == '0)) state_d = ARMED;
                end
            end
            WAIT_REL: begin
                if (btn_stable && (btn_sync == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign armed_d = (state_d == ARMED) || (state_d == WAIT_REL_RETRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            armed        <= 1'b0;
            vote_valid   <= 1'b0;
            vote_cand    <= '0;
            vote_invalid <= 1'b0;
            vote_timeout <= 1'b0;
        end else if (!power) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            armed        <= 1'b0;
            vote_valid   <= 1'b0;
            vote_cand    <= '0;
            vote_invalid <= 1'b0;
            vote_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            armed        <= armed_d;
            vote_valid   <= valid_d;
            vote_cand    <= cand_d;
            vote_invalid <= invalid_d;
            vote_timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
// Self-checking bench for vote_ballot_ctrl: a cycle reference model checked
// every cycle, a table of selections, hand-written corner sequences and a
// randomized phase.
module tb_vote_ballot_ctrl;

    localparam int D = 4;
    localparam int T = 32;

    logic       clk, rst, power, closed, ballot;
    logic [3:0] btn_in;
    logic       armed, vote_valid, vote_invalid, vote_timeout;
    logic [1:0] vote_cand;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    vote_ballot_ctrl #(
        .DEBOUNCE_CYC(D),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .power       (power),
        .closed      (closed),
        .ballot      (ballot),
        .btn_in      (btn_in),
        .armed       (armed),
        .vote_valid  (vote_valid),
        .vote_cand   (vote_cand),
        .vote_invalid(vote_invalid),
        .vote_timeout(vote_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample histories of the raw inputs as seen at each rising edge:
    // btn_hist[0] is the previous edge, btn_hist[i] is i+1 edges back.
    logic [3:0] btn_hist [0:D];
    bit         bal_hist [0:2];
    int         since_clr;
    int         m_phase;   // 0 idle, 1 voting, 2 after vote, 3 after invalid
    int         m_age;
    bit         e_armed, e_valid, e_invalid, e_timeout;
    logic [1:0] e_cand;

    task automatic model_clear();
        for (int i = 0; i <= D; i++) btn_hist[i] = '0;
        for (int i = 0; i < 3; i++) bal_hist[i] = 1'b0;
        since_clr = 0;
        m_phase = 0; m_age = 0;
        e_armed = 0; e_valid = 0; e_invalid = 0; e_timeout = 0; e_cand = '0;
    endtask

    task automatic model_step();
        bit         stable, rise;
        logic [3:0] sel;
        sel    = btn_hist[0];
        stable = (since_clr >= D - 1);
        for (int i = 1; i <= D; i++) if (btn_hist[i] != sel) stable = 0;
        rise = bal_hist[1] && !bal_hist[2];
        e_valid = 0; e_invalid = 0; e_timeout = 0; e_cand = '0;
        case (m_phase)
            0: if (rise && !closed) begin m_phase = 1; m_age = 0; end
            1: begin
                if (stable && $countones(sel) == 1) begin
                    e_valid = 1; e_cand = 2'($clog2(sel)); m_phase = 2;
                end else if (stable && $countones(sel) > 1) begin
                    e_invalid = 1; m_phase = 3;
                    if (m_age < T - 1) m_age++;
                end else if (m_age == T - 1) begin
                    e_timeout = 1; m_phase = 0;
                end else m_age++;
            end
            3: begin
                if (m_age == T - 1) begin
                    e_timeout = 1; m_phase = 0;
                end else begin
                    m_age++;
                    if (stable && sel == 0) m_phase = 1;
                end
            end
            default: if (stable && sel == 0) m_phase = 0;
        endcase
        e_armed = (m_phase == 1) || (m_phase == 3);
        for (int i = D; i > 0; i--) btn_hist[i] = btn_hist[i-1];
        btn_hist[0] = btn_in;
        bal_hist[2] = bal_hist[1]; bal_hist[1] = bal_hist[0]; bal_hist[0] = ballot;
        since_clr++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || !power) model_clear();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model", {armed, vote_valid, (vote_valid ? vote_cand : 2'b00), vote_invalid, vote_timeout},
                  {e_armed, e_valid, e_cand, e_invalid, e_timeout});
    end

    // ---------------- helpers ----------------
    task automatic wait_armed(input string name);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = armed;
        end
        check(name, seen, 1);
    endtask

    task automatic arm_ballot(input string name);
        @(negedge clk) ballot = 1'b1;
        repeat (2) @(negedge clk);
        ballot = 1'b0;
        wait_armed(name);
    endtask

    task automatic count_pulses(input int cycles, output int nv, output int ni, output int nt,
                                output logic [1:0] cand);
        nv = 0; ni = 0; nt = 0; cand = 2'b00;
        repeat (cycles) begin
            @(negedge clk);
            if (vote_valid) begin nv++; cand = vote_cand; end
            if (vote_invalid) ni++;
            if (vote_timeout) nt++;
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] btn;
        bit         exp_valid;
        logic [1:0] exp_cand;
        bit         exp_invalid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, ni, nt, n;
        logic [1:0] c;
        logic [3:0] p;

        vecs[0] = '{"oh0", 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{"oh1", 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[2] = '{"oh2", 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[3] = '{"oh3", 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[4] = '{"mh0101", 4'b0101, 1'b0, 2'd0, 1'b1};
        vecs[5] = '{"mh1111", 4'b1111, 1'b0, 2'd0, 1'b1};
        vecs[6] = '{"mh0110", 4'b0110, 1'b0, 2'd0, 1'b1};
        vecs[7] = '{"mh1001", 4'b1001, 1'b0, 2'd0, 1'b1};

        rst = 1'b1; power = 1'b0; closed = 1'b0; ballot = 1'b0; btn_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {armed, vote_valid, vote_cand, vote_invalid, vote_timeout}, 0);
        rst = 1'b0; power = 1'b1;
        chk_en = 1;
        repeat (10) @(negedge clk);

        // 25 ns ballot pulse, then exact press-to-pulse latency
        @(negedge clk) #2 ballot = 1'b1;
        #25 ballot = 1'b0;
        wait_armed("arm_25ns");
        btn_in = 4'b0001;
        for (int i = 0; i < D + 1; i++) begin
            @(negedge clk);
            check("latency_early", vote_valid, 0);
        end
        @(negedge clk);
        check("latency_valid", vote_valid, 1);
        check("latency_cand", vote_cand, 0);
        check("latency_armed_drop", armed, 0);
        btn_in = '0;
        count_pulses(10, nv, ni, nt, c);
        check("after_vote_quiet", nv + ni + nt, 0);
        check("after_vote_idle", armed, 0);

        // selection table
        for (int i = 0; i < 8; i++) begin
            arm_ballot({vecs[i].name, "_arm"});
            btn_in = vecs[i].btn;
            count_pulses(8, nv, ni, nt, c);
            check({vecs[i].name, "_valid"}, nv, 32'(vecs[i].exp_valid));
            check({vecs[i].name, "_invalid"}, ni, 32'(vecs[i].exp_invalid));
            if (vecs[i].exp_valid) check({vecs[i].name, "_cand"}, c, vecs[i].exp_cand);
            btn_in = '0;
            if (vecs[i].exp_invalid) begin
                count_pulses(8, nv, ni, nt, c);
                check({vecs[i].name, "_still_armed"}, armed, 1);
                btn_in = 4'b1000;
                count_pulses(8, nv, ni, nt, c);
                check({vecs[i].name, "_retry_valid"}, nv, 1);
                check({vecs[i].name, "_retry_cand"}, c, 3);
                btn_in = '0;
            end
            count_pulses(8, nv, ni, nt, c);
            check({vecs[i].name, "_released"}, armed, 0);
        end

        // short glitch, then a held vote slid into another candidate
        arm_ballot("glitch_arm");
        btn_in = 4'b0010;
        repeat (2) @(negedge clk);
        btn_in = '0;
        count_pulses(8, nv, ni, nt, c);
        check("glitch_no_pulse", nv + ni + nt, 0);
        btn_in = 4'b0010;
        count_pulses(20, nv, ni, nt, c);
        btn_in = 4'b0001;
        count_pulses(10, n, ni, nt, p[1:0]);
        check("slide_one_vote", nv + n, 1);
        check("slide_cand", c, 1);
        btn_in = '0;
        count_pulses(10, nv, ni, nt, c);
        check("slide_no_second", nv, 0);

        // idle presses, closed vs ballot, closed while armed
        btn_in = 4'b0001;
        count_pulses(20, nv, ni, nt, c);
        check("idle_press_quiet", nv + ni + nt + 32'(armed), 0);
        btn_in = '0;
        repeat (8) @(negedge clk);
        @(negedge clk) begin ballot = 1'b1; closed = 1'b1; end
        repeat (2) @(negedge clk);
        ballot = 1'b0;
        count_pulses(6, nv, ni, nt, c);
        check("closed_blocks", armed, 0);
        closed = 1'b0;
        repeat (4) @(negedge clk);
        arm_ballot("closed_mid_arm");
        closed = 1'b1;
        btn_in = 4'b0100;
        count_pulses(8, nv, ni, nt, c);
        check("closed_mid_vote", nv, 1);
        check("closed_mid_cand", c, 2);
        btn_in = '0; closed = 1'b0;
        repeat (8) @(negedge clk);

        // timeout length
        arm_ballot("to_arm");
        n = 1;
        for (int i = 0; i < T + 8; i++) begin
            @(negedge clk);
            if (!armed) break;
            n++;
        end
        check("to_armed_cycles", n, T);
        check("to_pulse", vote_timeout, 1);
        repeat (4) @(negedge clk);

        // vote decision on the expiry cycle wins
        arm_ballot("tie_arm");
        repeat (T - 6) @(negedge clk);
        btn_in = 4'b0001;
        repeat (6) @(negedge clk);
        check("tie_valid", vote_valid, 1);
        check("tie_no_timeout", vote_timeout, 0);
        @(negedge clk);
        check("tie_no_late_timeout", vote_timeout, 0);
        btn_in = '0;
        repeat (8) @(negedge clk);

        // one cycle too late: expiry only
        arm_ballot("late_arm");
        repeat (T - 5) @(negedge clk);
        btn_in = 4'b0001;
        repeat (5) @(negedge clk);
        check("late_timeout", vote_timeout, 1);
        count_pulses(8, nv, ni, nt, c);
        check("late_no_vote", nv, 0);
        btn_in = '0;
        repeat (8) @(negedge clk);

        // power drop mid-ARMED
        arm_ballot("pwr_arm");
        repeat (2) @(negedge clk);
        power = 1'b0;
        @(negedge clk);
        check("pwr_clear", armed, 0);
        repeat (3) @(negedge clk);
        power = 1'b1;
        repeat (4) @(negedge clk);
        arm_ballot("pwr_rearm");
        btn_in = 4'b1000;
        count_pulses(8, nv, ni, nt, c);
        check("pwr_vote", nv, 1);
        check("pwr_cand", c, 3);
        btn_in = '0;
        repeat (8) @(negedge clk);

        // async reset mid-WAIT_REL
        arm_ballot("rst_arm");
        btn_in = 4'b0100;
        nv = 0;
        for (int i = 0; i < 10 && nv == 0; i++) begin
            @(negedge clk);
            nv = vote_valid;
        end
        check("rst_pre_vote", nv, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_clear", {armed, vote_valid, vote_cand, vote_invalid, vote_timeout}, 0);
        @(negedge clk) rst = 1'b0;
        btn_in = '0;
        repeat (8) @(negedge clk);
        arm_ballot("rst_rearm");
        btn_in = 4'b0010;
        count_pulses(8, nv, ni, nt, c);
        check("rst_vote", nv, 1);
        check("rst_cand", c, 1);
        btn_in = '0;
        repeat (8) @(negedge clk);

        // randomized traffic against the model
        for (int ep = 0; ep < 60; ep++) begin
            if ($urandom_range(0, 3) != 0) begin
                closed = ($urandom_range(0, 7) == 0);
                @(negedge clk) ballot = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                ballot = 1'b0;
            end
            repeat ($urandom_range(1, 4)) begin
                n = $urandom_range(0, 9);
                if (n < 4) p = 4'b0001 << n;
                else if (n < 6) p = '0;
                else p = 4'($urandom);
                btn_in = p;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    btn_in = '0;
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                power = 1'b0;
                repeat (2) @(negedge clk);
                power = 1'b1;
            end
            closed = 1'b0;
        end
        btn_in = '0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
